// File: rtl/player_ctrl_pkg.sv
// Shared constants for the MP3 playback controller: command bytes, play modes
// and the parser / UART receiver state encodings.
package player_ctrl_pkg;

  localparam logic [7:0] CMD_PAUSE  = 8'h50;  // 'P'
  localparam logic [7:0] CMD_NEXT   = 8'h4E;  // 'N'
  localparam logic [7:0] CMD_PREV   = 8'h42;  // 'B'
  localparam logic [7:0] CMD_VOL_UP = 8'h2B;  // '+', attenuation down
  localparam logic [7:0] CMD_VOL_DN = 8'h2D;  // '-', attenuation up
  localparam logic [7:0] CMD_MODE   = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_SEL    = 8'h53;  // 'S', followed by an index byte
  localparam logic [7:0] CMD_MUTE   = 8'h58;  // 'X'

  typedef enum logic [1:0] {
    MODE_SEQ     = 2'd0,
    MODE_REP_ALL = 2'd1,
    MODE_REP_ONE = 2'd2
  } mode_e;

  typedef enum logic {
    P_IDLE     = 1'b0,
    P_WAIT_IDX = 1'b1
  } pstate_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rxstate_e;

  function automatic mode_e mode_next(input mode_e m);
    case (m)
      MODE_SEQ:     return MODE_REP_ALL;
      MODE_REP_ALL: return MODE_REP_ONE;
      default:      return MODE_SEQ;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with 2-FF input synchroniser and mid-bit sampling.
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a falling edge
//   RX_START | counting to start-bit middle, re-checking it is low
//   RX_DATA  | sampling 8 data bits LSB first
//   RX_STOP  | sampling stop bit, valid or frame error at its middle
module uart_rx_byte
  import player_ctrl_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);

  rxstate_e           r_state, w_state_nxt;
  logic               r_rx_s1, r_rx_s2, r_rx_d;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               w_fall, w_tc;

  assign w_fall = r_rx_d & ~r_rx_s2;
  assign w_tc   = (r_cnt == '0);
  assign o_data = r_shift;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RX_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_state_nxt = RX_START;
      RX_START: if (w_tc) w_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tc && r_bit_cnt == 3'd7) w_state_nxt = RX_STOP;
      RX_STOP:  if (w_tc) w_state_nxt = RX_IDLE;
      default:  w_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    o_valid     = 1'b0;
    o_frame_err = 1'b0;
    if (r_state == RX_STOP && w_tc) begin
      o_valid     = r_rx_s2;
      o_frame_err = ~r_rx_s2;
    end
  end

  // Synchroniser resets high so reset release never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_d    <= 1'b1;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
      if (r_state == RX_IDLE) begin
        r_cnt     <= CNT_W'(HALF - 1);
        r_bit_cnt <= '0;
      end else if (w_tc) begin
        r_cnt <= CNT_W'(DIV - 1);
        if (r_state == RX_DATA) begin
          r_shift   <= {r_rx_s2, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// MP3 playback controller: UART command parser, volume/song/pause/mode state
// and end-of-track handling. Define PLAYER_CTRL_MUTE_EN to build the 'X' mute toggle.
//   state      | meaning
//   P_IDLE     | waiting for a command byte
//   P_WAIT_IDX | 'S' received, waiting (with timeout) for the index byte
module player_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int               CLK_HZ          = 100_000_000,
  parameter int               BAUD            = 9600,
  parameter int               NUM_SONGS       = 4,
  parameter int               VOL_W           = 8,
  parameter int               VOL_STEP        = 8,
  parameter logic [VOL_W-1:0] VOL_DEFAULT     = 8'h20,
  parameter int               IDX_TIMEOUT_CYC = CLK_HZ / 10,
  parameter int               SONG_W          = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 i_finish,
  output logic [2*VOL_W-1:0]   o_vol,
  output logic [SONG_W-1:0]    o_song,
  output logic                 o_song_change,
  output logic                 o_pause,
  output logic [1:0]           o_mode,
  output logic                 o_cmd_err
);

  localparam int                TO_W = (IDX_TIMEOUT_CYC > 1) ? $clog2(IDX_TIMEOUT_CYC) : 1;
  localparam logic [SONG_W-1:0] LAST = SONG_W'(NUM_SONGS - 1);
  localparam logic [VOL_W-1:0]  STEP = VOL_W'(VOL_STEP);
  localparam logic [VOL_W-1:0]  VMAX = '1;

  logic [7:0]        w_rx_data;
  logic              w_rx_valid, w_rx_err;
  pstate_e           r_state, w_state_nxt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              w_to_tc;
  logic              r_fin_q, r_fin_qq, w_fin_edge, w_fin_act;
  logic [SONG_W-1:0] r_song, w_song_nxt, w_song_inc, w_song_dec;
  logic              r_pause, w_pause_nxt;
  mode_e             r_mode;
  logic [VOL_W-1:0]  r_att;
  logic              r_song_change, r_cmd_err;
  logic              w_cmd_pause, w_cmd_next, w_cmd_prev, w_cmd_vol_up, w_cmd_vol_dn;
  logic              w_cmd_mode, w_cmd_sel, w_cmd_err, w_song_cmd;
`ifdef PLAYER_CTRL_MUTE_EN
  logic              w_cmd_mute, r_mute;
`endif

  uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .o_data      (w_rx_data),
    .o_valid     (w_rx_valid),
    .o_frame_err (w_rx_err)
  );

  assign w_to_tc = (r_to_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= P_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      P_IDLE:     if (w_rx_valid && w_rx_data == CMD_SEL) w_state_nxt = P_WAIT_IDX;
      P_WAIT_IDX: if (w_rx_valid || w_to_tc) w_state_nxt = P_IDLE;
      default:    w_state_nxt = P_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_pause  = 1'b0;
    w_cmd_next   = 1'b0;
    w_cmd_prev   = 1'b0;
    w_cmd_vol_up = 1'b0;
    w_cmd_vol_dn = 1'b0;
    w_cmd_mode   = 1'b0;
    w_cmd_sel    = 1'b0;
    w_cmd_err    = w_rx_err;
`ifdef PLAYER_CTRL_MUTE_EN
    w_cmd_mute   = 1'b0;
`endif
    if (r_state == P_IDLE) begin
      if (w_rx_valid) begin
        case (w_rx_data)
          CMD_PAUSE:  w_cmd_pause  = 1'b1;
          CMD_NEXT:   w_cmd_next   = 1'b1;
          CMD_PREV:   w_cmd_prev   = 1'b1;
          CMD_VOL_UP: w_cmd_vol_up = 1'b1;
          CMD_VOL_DN: w_cmd_vol_dn = 1'b1;
          CMD_MODE:   w_cmd_mode   = 1'b1;
          CMD_SEL:    ;
`ifdef PLAYER_CTRL_MUTE_EN
          CMD_MUTE:   w_cmd_mute   = 1'b1;
`endif
          default:    w_cmd_err    = 1'b1;
        endcase
      end
    end else if (w_rx_valid) begin
      if (int'(w_rx_data) < NUM_SONGS) w_cmd_sel = 1'b1;
      else                             w_cmd_err = 1'b1;
    end else if (w_to_tc) begin
      w_cmd_err = 1'b1;
    end
  end

  // Counter idles at its reload value and only runs while waiting for the index
  always_ff @(posedge clk) begin
    if (rst || r_state == P_IDLE) r_to_cnt <= TO_W'(IDX_TIMEOUT_CYC - 1);
    else if (!w_to_tc)            r_to_cnt <= r_to_cnt - 1'b1;
  end

  assign w_fin_edge = r_fin_q & ~r_fin_qq;
  assign w_song_cmd = w_cmd_next | w_cmd_prev | w_cmd_sel;
  assign w_fin_act  = w_fin_edge & ~w_song_cmd;
  assign w_song_inc = (r_song == LAST) ? '0 : r_song + 1'b1;
  assign w_song_dec = (r_song == '0) ? LAST : r_song - 1'b1;

  always_comb begin
    w_song_nxt = r_song;
    if (w_cmd_next)      w_song_nxt = w_song_inc;
    else if (w_cmd_prev) w_song_nxt = w_song_dec;
    else if (w_cmd_sel)  w_song_nxt = w_rx_data[SONG_W-1:0];
    else if (w_fin_act && r_mode != MODE_REP_ONE) w_song_nxt = w_song_inc;
  end

  always_comb begin
    w_pause_nxt = r_pause ^ w_cmd_pause;
    if (w_song_cmd) w_pause_nxt = 1'b0;
    else if (w_fin_act && r_mode == MODE_SEQ && r_song == LAST) w_pause_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fin_q       <= 1'b0;
      r_fin_qq      <= 1'b0;
      r_song        <= '0;
      r_pause       <= 1'b0;
      r_mode        <= MODE_SEQ;
      r_att         <= VOL_DEFAULT;
      r_song_change <= 1'b0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_fin_q       <= i_finish;
      r_fin_qq      <= r_fin_q;
      r_song        <= w_song_nxt;
      r_pause       <= w_pause_nxt;
      r_song_change <= w_song_cmd | w_fin_act;
      r_cmd_err     <= w_cmd_err;
      if (w_cmd_mode) r_mode <= mode_next(r_mode);
      if (w_cmd_vol_up)      r_att <= (r_att < STEP) ? '0 : r_att - STEP;
      else if (w_cmd_vol_dn) r_att <= (r_att > VMAX - STEP) ? VMAX : r_att + STEP;
    end
  end

`ifdef PLAYER_CTRL_MUTE_EN
  always_ff @(posedge clk) begin
    if (rst)             r_mute <= 1'b0;
    else if (w_cmd_mute) r_mute <= ~r_mute;
  end
  assign o_vol = r_mute ? '1 : {r_att, r_att};
`else
  assign o_vol = {r_att, r_att};
`endif

  assign o_song        = r_song;
  assign o_song_change = r_song_change;
  assign o_pause       = r_pause;
  assign o_mode        = r_mode;
  assign o_cmd_err     = r_cmd_err;

endmodule

// File: doc/player_ctrl.md
# player_ctrl

Parametrised playback controller for the MP3 player. It receives single-byte and two-byte commands over a UART link from the Bluetooth module and maintains the player state: volume, song index, pause and play mode. It advances songs automatically when the decoder reports end-of-track. It sits between the Bluetooth RX pin and the `mp3` decoder driver, and generalises the earlier fixed two-song, toggle-only command path to N songs, a wider volume range, two-byte direct selection and repeat modes.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: system clock frequency.
- `BAUD`, 9600: UART bit rate, 8N1.
- `NUM_SONGS`, 4: number of tracks, ≥2.
- `VOL_W`, 8: per-channel attenuation width.
- `VOL_STEP`, 8: attenuation change per `+`/`-` command.
- `VOL_DEFAULT`, 8'h20: reset attenuation for each channel.
- `IDX_TIMEOUT_CYC`, CLK_HZ/10: time limit for the second byte of an `S` command.

Ports (`SONG_W = max(1, clog2(NUM_SONGS))`):
- `clk`, in, 1: system clock. One clock domain only.
- `rst`, in, 1: synchronous, active-high reset.
- `rx`, in, 1: UART serial input. Asynchronous; idles high.
- `i_finish`, in, 1: end-of-track level from the decoder. The block acts on its rising edge.
- `o_vol`, out, 2*VOL_W: `{left, right}` attenuation in SCI_VOL format.
- `o_song`, out, SONG_W: current track index.
- `o_song_change`, out, 1: one-cycle pulse telling the decoder to (re)load the track.
- `o_pause`, out, 1: playback paused.
- `o_mode`, out, 2: play mode. 0 = SEQ, 1 = REP_ALL, 2 = REP_ONE.
- `o_cmd_err`, out, 1: one-cycle pulse on a framing error, an unknown byte, a bad index or a timeout.

## Operation
- **UART receiver**
  - `rx` passes through a 2-FF synchroniser.
  - A falling edge starts a frame. The start bit is re-checked at mid-bit; if it is not low, the frame is dropped silently.
  - Data bits are sampled LSB first at mid-bit, using `DIV = round(CLK_HZ/BAUD)`.
  - If the stop bit samples low, the byte is dropped and `o_cmd_err` pulses.
- **Parser states: IDLE, WAIT_IDX**
  - `P` (0x50): toggle `o_pause`.
  - `N` (0x4E): song = song+1, wrapping to 0 at the end. Clears pause and pulses `o_song_change`.
  - `B` (0x42): song = song−1, wrapping to NUM_SONGS−1. Clears pause and pulses `o_song_change`.
  - `+` (0x2B): both channels' attenuation −VOL_STEP, saturating at 0.
  - `-` (0x2D): both channels' attenuation +VOL_STEP, saturating at 2^VOL_W−1.
  - `M` (0x4D): mode cycles SEQ→REP_ALL→REP_ONE→SEQ.
  - `S` (0x53): go to WAIT_IDX and start the timeout counter.
  - Any other byte: ignored, and `o_cmd_err` pulses.
- **WAIT_IDX state**
  - The next byte is a binary index. If index < NUM_SONGS: song = index, pause cleared, `o_song_change` pulses. Otherwise `o_cmd_err` pulses and the song is unchanged.
  - Either way the parser returns to IDLE.
  - If IDX_TIMEOUT_CYC cycles pass with no byte, the parser returns to IDLE and `o_cmd_err` pulses.
- **Finish handling (rising edge of `i_finish`)**
  - REP_ONE: song unchanged; `o_song_change` pulses.
  - REP_ALL: song+1, wrapping; `o_song_change` pulses.
  - SEQ, song not last: song+1; `o_song_change` pulses.
  - SEQ, last song: song = 0, pause = 1, `o_song_change` pulses.
- **Simultaneous events**
  - If a song-changing command (`N`, `B`, valid index) lands in the same cycle as a finish edge, the command wins and the finish edge is discarded.
  - If the command does not change the song, both the command and the finish edge take effect.

## Timing
- Reset values:
  - `o_vol = {VOL_DEFAULT, VOL_DEFAULT}`, `o_song = 0`, `o_pause = 0`, `o_mode = 0`, `o_song_change = 0`, `o_cmd_err = 0`.
  - Parser in IDLE; receiver in idle.
  - The finish-edge register is loaded with 0, so `i_finish` already high at reset release counts as an edge.
- The receiver produces its byte-valid at the mid-point of the stop bit. All outputs update on the next clock edge (1-cycle latency). `o_song_change` and the new `o_song` appear in the same cycle.
- The finish edge is detected with a 1-cycle register. Outputs update 1 cycle after the edge, so 2 cycles after `i_finish` rises.
- Reset mid-frame or while in WAIT_IDX aborts the frame or command with no error pulse.
- A new start bit is accepted one cycle after the stop-bit sample, so back-to-back bytes work.

## Configuration
- `PLAYER_CTRL_MUTE_EN` defined: command `X` (0x58) toggles mute.
  - While muted, `o_vol` = all ones on both channels.
  - The stored attenuation is kept; `+`/`-` still modify it.
  - Un-muting restores the stored value. Reset clears mute.
- `PLAYER_CTRL_MUTE_EN` undefined: `X` is an unknown byte and pulses `o_cmd_err`; no mute logic is built.

## Structure
- Package `player_ctrl_pkg`: command byte constants, mode encoding (SEQ/REP_ALL/REP_ONE), parser state encoding.
- Sub-module `uart_rx_byte`, parameters CLK_HZ and BAUD. Ports: `clk`, `rst`, `rx` → `o_data[7:0]`, `o_valid` (1-cycle pulse), `o_frame_err`.
- `player_ctrl` holds the parser FSM, timeout counter, finish-edge detector and state registers.

## Test plan
All tests use defaults (DIV = 10417).
- Send `N`, `N`, `B` → `o_song` goes 1, 2, 1, with one `o_song_change` pulse per byte, each 1 cycle after the stop mid-bit.
- Send `-` 40 times from reset → `o_vol` = 16'hFFFF, saturated with no wrap. Then send `+` 5 times → 16'hD7D7.
- Send `S`, 0x03 → `o_song` = 3. Send `S`, 0x07 → `o_cmd_err` pulses and the song stays 3. Send `S` then nothing for 10 M cycles → `o_cmd_err` pulses and the next byte `P` sets `o_pause` = 1.
- Mode SEQ, song 3, pulse `i_finish` → song 0, pause 1. After `M` (REP_ALL), song 3 with finish → song 0, pause 0. After another `M` (REP_ONE), finish → song unchanged with a change pulse.
- Send a frame with stop bit 0 → no state change and `o_cmd_err` pulses. Send byte 0x41 → `o_cmd_err` pulses.
- Finish edge in the same cycle as the valid for `B` at song 2, mode REP_ALL → song 1, a single change pulse. With the macro on: `X` → `o_vol` = 16'hFFFF; `X` again → 16'h2020.
